wall_scroller: RTL and testbench

WALL_SCROLLER -- requirements
Module: wall_scroller

---
 rtl/wall_scroller_pkg.sv | 26 ++
 rtl/wall_scroller_if.sv | 24 ++
 rtl/wall_scroller_gap_clamp.sv | 18 +
 rtl/wall_scroller.sv | 87 ++++++++
 tb/tb_wall_scroller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wall_scroller_pkg.sv
// Shared game constants, derived widths and FSM state encoding for the wall scroller.
package wall_scroller_pkg;

   localparam int unsigned SCREEN_W   = 160;
   localparam int unsigned SCREEN_H   = 120;
   localparam int unsigned WALL_W     = 8;
   localparam int unsigned GAP_H      = 40;
   localparam int unsigned BIRD_X     = 20;
   localparam int unsigned SPEED      = 1;
   localparam int unsigned GAP_MARGIN = 4;

   localparam int unsigned X_W     = 8;
   localparam int unsigned H_W     = 8;
   localparam int unsigned GAP_W   = 7;
   localparam int unsigned EDGE_W  = X_W + 1;
   localparam int unsigned GAP_MIN = GAP_MARGIN;
   localparam int unsigned GAP_MAX = SCREEN_H - GAP_H - GAP_MARGIN;
   localparam int unsigned X_START = SCREEN_W - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      SCROLL = 2'd2
   } state_t;

endpackage

// File: rtl/wall_scroller_if.sv
// Height handshake from the random generator plus the wall geometry published to the renderer.
interface wall_scroller_if;
   import wall_scroller_pkg::*;

   logic             height_valid;
   logic [H_W-1:0]   height_in;
   logic             height_ready;
   logic [X_W-1:0]   wall_x;
   logic [GAP_W-1:0] gap_top;
   logic [GAP_W-1:0] gap_bot;
   logic             wall_valid;
   logic             passed;

   modport master (
      output height_valid, height_in,
      input  height_ready, wall_x, gap_top, gap_bot, wall_valid, passed
   );

   modport slave (
      input  height_valid, height_in,
      output height_ready, wall_x, gap_top, gap_bot, wall_valid, passed
   );

endinterface

// File: rtl/wall_scroller_gap_clamp.sv
// Clamps a raw 8-bit height into the legal gap_top range; compare is done at full width.
module gap_clamp
   import wall_scroller_pkg::*;
(
   input  logic [H_W-1:0]   raw,
   output logic [GAP_W-1:0] gap
);

   always_comb begin
      gap = raw[GAP_W-1:0];
      if (raw < H_W'(GAP_MIN)) begin
         gap = GAP_W'(GAP_MIN);
      end else if (raw > H_W'(GAP_MAX)) begin
         gap = GAP_W'(GAP_MAX);
      end
   end

endmodule

// File: rtl/wall_scroller.sv
// Single scrolling wall: fetches a gap height, scrolls left once per frame, flags when the bird is passed.
module wall_scroller
   import wall_scroller_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            frame_tick,
   wall_scroller_if.slave  bus
);

   state_t             state;
   state_t             state_nx;
   logic [X_W-1:0]     x_nx;
   logic [GAP_W-1:0]   clamped;
   logic               xfer_c;
   logic               dec_c;
   logic               pass_c;
   logic [EDGE_W-1:0]  edge_old;
   logic [EDGE_W-1:0]  edge_new;

   gap_clamp u_gap_clamp (
      .raw (bus.height_in),
      .gap (clamped)
   );

   // Next state, next wall position and the bird-crossing detect.
   always_comb begin
      state_nx = state;
      x_nx     = bus.wall_x;
      xfer_c   = 1'b0;
      dec_c    = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nx = FETCH;
         end
         FETCH: begin
            if (enable && bus.height_valid && bus.height_ready) begin
               xfer_c   = 1'b1;
               state_nx = SCROLL;
               x_nx     = X_W'(X_START);
            end
         end
         SCROLL: begin
            if (enable && frame_tick) begin
               if (bus.wall_x < X_W'(SPEED)) begin
                  state_nx = FETCH;
               end else begin
                  dec_c = 1'b1;
                  x_nx  = bus.wall_x - X_W'(SPEED);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      edge_old = {1'b0, bus.wall_x} + EDGE_W'(WALL_W);
      edge_new = {1'b0, x_nx} + EDGE_W'(WALL_W);
      pass_c   = dec_c && (edge_old > EDGE_W'(BIRD_X)) && (edge_new <= EDGE_W'(BIRD_X));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wall_x       <= X_W'(X_START);
         bus.gap_top      <= GAP_W'(GAP_MIN);
         bus.gap_bot      <= GAP_W'(GAP_MIN + GAP_H - 1);
         bus.height_ready <= 1'b0;
         bus.wall_valid   <= 1'b0;
         bus.passed       <= 1'b0;
      end else begin
         bus.wall_x <= x_nx;
         if (xfer_c) begin
            bus.gap_top <= clamped;
            bus.gap_bot <= clamped + GAP_W'(GAP_H - 1);
         end
         bus.height_ready <= (state_nx == FETCH) && enable;
         bus.wall_valid   <= (state_nx == SCROLL);
         bus.passed       <= pass_c;
      end
   end

endmodule

// File: tb/tb_wall_scroller.sv
// Self-checking bench for wall_scroller: directed scenarios plus randomized tick spacing and heights.
module tb_wall_scroller;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int SCR_W  = 160;
   localparam int GAP_HT = 40;
   localparam int LO     = 4;
   localparam int HI     = 120 - 40 - 4;
   localparam int BIRD   = 20;
   localparam int WALLW  = 8;

   wall_scroller_if bus ();

   wall_scroller dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .frame_tick (frame_tick),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int clamp_ref(input int h);
      if (h < LO) return LO;
      if (h > HI) return HI;
      return h;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Reset, then load one wall with the given raw height; leaves the DUT in SCROLL at x=159.
   task automatic load_wall(input int h);
      reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; bus.height_valid = 1'b0;
      step();
      reset = 1'b0; enable = 1'b1;
      bus.height_valid = 1'b1; bus.height_in = 8'(h);
      step();
      step();
      bus.height_valid = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1; frame_tick = 1'b1; bus.height_valid = 1'b1; bus.height_in = 8'd50;
      reset = 1'b1;
      step();
      reset = 1'b0; enable = 1'b0; frame_tick = 1'b0; bus.height_valid = 1'b0;
      n_checks++;
      if (bus.wall_x !== 8'd159 || bus.gap_top !== 7'd4 || bus.gap_bot !== 7'd43) begin
         n_fail++;
         $display("FAIL reset_geom: wall_x=%0d gap_top=%0d gap_bot=%0d want 159/4/43",
                  bus.wall_x, bus.gap_top, bus.gap_bot);
      end
      n_checks++;
      if ({bus.height_ready, bus.wall_valid, bus.passed} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: ready/valid/passed=%b want 000",
                  {bus.height_ready, bus.wall_valid, bus.passed});
      end
      step();
      n_checks++;
      if (bus.height_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: height_ready=%b want 0 while enable=0", bus.height_ready);
      end
   endtask

   task automatic test_first_wall();
      enable = 1'b1; bus.height_valid = 1'b1; bus.height_in = 8'd30;
      step();
      n_checks++;
      if (bus.height_ready !== 1'b1 || bus.wall_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_entry: ready=%b valid=%b want 1/0", bus.height_ready, bus.wall_valid);
      end
      step();
      bus.height_valid = 1'b0;
      n_checks++;
      if (bus.gap_top !== 7'd30 || bus.gap_bot !== 7'd69 || bus.wall_x !== 8'd159 ||
          bus.wall_valid !== 1'b1 || bus.height_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL first_wall: top=%0d bot=%0d x=%0d valid=%b ready=%b want 30/69/159/1/0",
                  bus.gap_top, bus.gap_bot, bus.wall_x, bus.wall_valid, bus.height_ready);
      end
   endtask

   // Full traversal with random idle cycles between ticks; the model is the wall position as an integer.
   task automatic test_scroll_pass();
      int exp_x = SCR_W - 1;
      int npass = 0;
      bit exited = 1'b0;
      bit exp_pass;
      for (int i = 0; i < 160; i++) begin
         int idle = $urandom_range(0, 2);
         for (int k = 0; k < idle; k++) begin
            step();
            n_checks++;
            if (bus.wall_x !== 8'(exp_x) || bus.passed !== 1'b0) begin
               n_fail++;
               $display("FAIL scroll_idle: x=%0d passed=%b want %0d/0", bus.wall_x, bus.passed, exp_x);
            end
         end
         tick();
         exp_pass = 1'b0;
         if (exp_x == 0) begin
            exited = 1'b1;
         end else begin
            exp_pass = (exp_x + WALLW > BIRD) && (exp_x - 1 + WALLW <= BIRD);
            exp_x--;
         end
         if (bus.passed === 1'b1) npass++;
         n_checks++;
         if (bus.wall_x !== 8'(exp_x) || bus.passed !== exp_pass) begin
            n_fail++;
            $display("FAIL scroll_tick%0d: x=%0d passed=%b want %0d/%b",
                     i, bus.wall_x, bus.passed, exp_x, exp_pass);
         end
      end
      n_checks++;
      if (npass != 1) begin
         n_fail++;
         $display("FAIL pass_count: got %0d pulses want 1", npass);
      end
      n_checks++;
      if (!exited || bus.height_ready !== 1'b1 || bus.wall_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL exit_fetch: ready=%b valid=%b want 1/0", bus.height_ready, bus.wall_valid);
      end
   endtask

   task automatic test_fetch_hold();
      bus.height_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (bus.wall_x !== 8'd0 || bus.height_ready !== 1'b1 || bus.wall_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold%0d: x=%0d ready=%b valid=%b want 0/1/0",
                     i, bus.wall_x, bus.height_ready, bus.wall_valid);
         end
      end
   endtask

   // Transfer coinciding with a frame tick: the new wall starts undecremented.
   task automatic test_back_to_back();
      bus.height_valid = 1'b1; bus.height_in = 8'd93;
      tick();
      bus.height_valid = 1'b0;
      n_checks++;
      if (bus.wall_x !== 8'd159 || bus.gap_top !== 7'd76 || bus.gap_bot !== 7'd115 ||
          bus.wall_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_xfer: x=%0d top=%0d bot=%0d valid=%b want 159/76/115/1",
                  bus.wall_x, bus.gap_top, bus.gap_bot, bus.wall_valid);
      end
   endtask

   task automatic test_clamp();
      int h;
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      h = 0;
         else if (i == 1) h = 93;
         else if (i == 2) h = 255;
         else if (i == 3) h = 76;
         else if (i == 4) h = 3;
         else             h = $urandom_range(0, 255);
         load_wall(h);
         n_checks++;
         if (bus.gap_top !== 7'(clamp_ref(h)) || bus.gap_bot !== 7'(clamp_ref(h) + GAP_HT - 1)) begin
            n_fail++;
            $display("FAIL clamp_h%0d: top=%0d bot=%0d want %0d/%0d",
                     h, bus.gap_top, bus.gap_bot, clamp_ref(h), clamp_ref(h) + GAP_HT - 1);
         end
      end
   endtask

   task automatic test_enable_freeze();
      load_wall(50);
      ticks(79);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (bus.wall_x !== 8'd80 || bus.wall_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze%0d: x=%0d valid=%b want 80/1", i, bus.wall_x, bus.wall_valid);
         end
      end
      enable = 1'b1;
      step();
      n_checks++;
      if (bus.wall_x !== 8'd80) begin
         n_fail++;
         $display("FAIL resume_idle: x=%0d want 80", bus.wall_x);
      end
      tick();
      n_checks++;
      if (bus.wall_x !== 8'd79) begin
         n_fail++;
         $display("FAIL resume_tick: x=%0d want 79", bus.wall_x);
      end
   endtask

   task automatic test_reset_mid();
      load_wall(60);
      ticks(109);
      n_checks++;
      if (bus.wall_x !== 8'd50) begin
         n_fail++;
         $display("FAIL pre_reset: x=%0d want 50", bus.wall_x);
      end
      reset = 1'b1; frame_tick = 1'b1; bus.height_valid = 1'b1;
      step();
      reset = 1'b0; frame_tick = 1'b0; bus.height_valid = 1'b0; enable = 1'b0;
      n_checks++;
      if (bus.wall_x !== 8'd159 || bus.wall_valid !== 1'b0 || bus.passed !== 1'b0 ||
          bus.height_ready !== 1'b0 || bus.gap_top !== 7'd4) begin
         n_fail++;
         $display("FAIL reset_mid: x=%0d valid=%b passed=%b ready=%b top=%0d want 159/0/0/0/4",
                  bus.wall_x, bus.wall_valid, bus.passed, bus.height_ready, bus.gap_top);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; frame_tick = 1'b0;
      bus.height_valid = 1'b0; bus.height_in = 8'd0;
      step();
      test_reset();
      test_first_wall();
      test_scroll_pass();
      test_fetch_hold();
      test_back_to_back();
      test_clamp();
      test_enable_freeze();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
